// File: rtl/tlk2711_pkg.sv
// Shared types for the tlk2711 AXI read arbiter: source ids, AR attribute payload, AR FSM states.
// No logic; imported by the arbiter top and its testbench.
package tlk2711_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  // Address is carried separately because its width is a module parameter.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [2:0] prot;
    logic [3:0] cache;
    logic       user;
  } ar_attr_t;

endpackage

// File: rtl/tlk2711_axi_rd_arbiter_if.sv
// AXI4 read address + read data channel bundle (no write channels, no RID).
// master drives AR and accepts R; slave is the mirror.
interface tlk2711_axi_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64
);
  logic                  arvalid;
  logic                  arready;
  logic [3:0]            arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [2:0]            arprot;
  logic [3:0]            arcache;
  logic                  aruser;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, arprot, arcache, aruser,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, arprot, arcache, aruser,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/tlk2711_src_fifo.sv
// 1-bit source-order FIFO, depth DEPTH (any value >= 2), pointers wrap modulo DEPTH.
// Output is the registered head; push ignored when full, pop ignored when empty.
module tlk2711_src_fifo #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tlk2711_axi_rd_arbiter.sv
// Round-robin share of one AXI4 read port between two DMA readers; AR latency 1 cycle, max 1 AR / 2 cycles.
// R beats follow a source-order FIFO; the head source's rready backpressures the PS, no new AR when FIFO full.
module tlk2711_axi_rd_arbiter
  import tlk2711_pkg::*;
#(
  parameter int         ADDR_WIDTH      = 48,
  parameter int         AXI_RDATA_WIDTH = 64,
  parameter int         OUTSTANDING     = 4,
  parameter logic [3:0] M_ARID          = 4'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  tlk2711_axi_rd_arbiter_if.slave  s0_axi,
  tlk2711_axi_rd_arbiter_if.slave  s1_axi,
  tlk2711_axi_rd_arbiter_if.master m_axi,
  output logic                     o_busy,
  output logic                     o_err_unexp_r
);

  localparam int CW = $clog2(OUTSTANDING + 1);

  state_t                state, state_nxt;
  logic                  last_grant;
  logic                  src_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  ar_attr_t              attr_q;
  ar_attr_t              attr0, attr1;
  logic                  room, grant, win, push, pop;
  logic                  fifo_head, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  unexp, unexp_d;

  assign attr0 = {s0_axi.arlen, s0_axi.arsize, s0_axi.arburst, s0_axi.arprot, s0_axi.arcache, s0_axi.aruser};
  assign attr1 = {s1_axi.arlen, s1_axi.arsize, s1_axi.arburst, s1_axi.arprot, s1_axi.arcache, s1_axi.aruser};

  // The burst being issued already holds a FIFO slot in the budget.
  assign room = (32'(fifo_count) + 32'(state == ISSUE)) < OUTSTANDING;

  always_comb begin
    state_nxt      = state;
    grant          = 1'b0;
    win            = SRC_A;
    push           = 1'b0;
    case (state)
      IDLE: begin
        if (room && (s0_axi.arvalid || s1_axi.arvalid)) begin
          grant     = 1'b1;
          win       = (s0_axi.arvalid && s1_axi.arvalid) ? ~last_grant : s1_axi.arvalid;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (m_axi.arready) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    s0_axi.arready = grant && (win == SRC_A);
    s1_axi.arready = grant && (win == SRC_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SRC_B;
      src_q      <= SRC_A;
      addr_q     <= '0;
      attr_q     <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        src_q  <= win;
        addr_q <= (win == SRC_B) ? s1_axi.araddr : s0_axi.araddr;
        attr_q <= (win == SRC_B) ? attr1 : attr0;
      end
      if (push) last_grant <= src_q;
    end
  end

  assign m_axi.arvalid = (state == ISSUE);
  assign m_axi.arid    = M_ARID;
  assign m_axi.araddr  = addr_q;
  assign {m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arprot, m_axi.arcache, m_axi.aruser} = attr_q;

  tlk2711_src_fifo #(.DEPTH(OUTSTANDING)) u_src_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (src_q),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Only the FIFO head source sees rvalid; rready is only taken from it.
  assign pop            = m_axi.rvalid && m_axi.rready && m_axi.rlast;
  assign s0_axi.rvalid  = !fifo_empty && (fifo_head == SRC_A) && m_axi.rvalid;
  assign s1_axi.rvalid  = !fifo_empty && (fifo_head == SRC_B) && m_axi.rvalid;
  assign m_axi.rready   = !fifo_empty && ((fifo_head == SRC_B) ? s1_axi.rready : s0_axi.rready);
  assign s0_axi.rdata   = m_axi.rdata;
  assign s0_axi.rresp   = m_axi.rresp;
  assign s0_axi.rlast   = m_axi.rlast;
  assign s1_axi.rdata   = m_axi.rdata;
  assign s1_axi.rresp   = m_axi.rresp;
  assign s1_axi.rlast   = m_axi.rlast;

  // A stalled unexpected beat raises the error once, not every cycle it waits.
  assign unexp  = fifo_empty && m_axi.rvalid;
  assign o_busy = !fifo_empty || (state == ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unexp_d       <= 1'b0;
      o_err_unexp_r <= 1'b0;
    end else begin
      unexp_d       <= unexp;
      o_err_unexp_r <= unexp && !unexp_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s0_axi.arid, s1_axi.arid, fifo_full};

endmodule

// File: tb/tb_tlk2711_axi_rd_arbiter.sv
// Bench for tlk2711_axi_rd_arbiter: directed timing scenarios plus a randomized two-source run
// checked against a grant/burst-order model with a simple PS responder.
module tb_tlk2711_axi_rd_arbiter;
  localparam int AW = 48;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;
  always #5 clk = ~clk;

  tlk2711_axi_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0 ();
  tlk2711_axi_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s1 ();
  tlk2711_axi_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m ();

  tlk2711_axi_rd_arbiter #(.ADDR_WIDTH(AW), .AXI_RDATA_WIDTH(DW), .OUTSTANDING(4), .M_ARID(4'h0)) dut (
    .clk(clk), .rst(rst), .s0_axi(s0), .s1_axi(s1), .m_axi(m), .o_busy(busy), .o_err_unexp_r(err)
  );

  int errors = 0;
  int checks = 0;
  int model_last;
  bit ps_auto = 0, ps_r_en = 0, r_hold = 0;
  int ps_beat = 0;
  int unsigned data_ctr = 0;
  int ps_q[$];
  logic [AW-1:0] ar_addr_q[$];
  int dlv_src[$];
  logic [DW-1:0] dlv_dat[$];
  int both_rv = 0;
  logic [AW-1:0] cur_addr[2];
  int cur_len[2];

  // Samples handshakes at the negative edge, where every input and output is settled.
  task automatic monitor();
    if (m.arvalid && m.arready) begin
      ps_q.push_back(int'(m.arlen));
      ar_addr_q.push_back(m.araddr);
    end
    if (s0.rvalid && s1.rvalid) both_rv++;
    if (s0.rvalid && s0.rready) begin dlv_src.push_back(0); dlv_dat.push_back(s0.rdata); end
    if (s1.rvalid && s1.rready) begin dlv_src.push_back(1); dlv_dat.push_back(s1.rdata); end
    if (ps_auto && m.rvalid && m.rready) begin
      data_ctr++;
      if (m.rlast) begin void'(ps_q.pop_front()); ps_beat = 0; end
      else ps_beat++;
    end
    r_hold = m.rvalid && !m.rready;
  endtask

  task automatic ps_drive();
    m.arready = ($urandom_range(0, 3) != 0);
    if (ps_r_en && ps_q.size() > 0) begin
      m.rvalid = r_hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      m.rdata  = DW'(data_ctr);
      m.rresp  = 2'b00;
      m.rlast  = (ps_beat == ps_q[0]);
    end else if (!r_hold) begin
      m.rvalid = 1'b0;
    end
  endtask

  task automatic adv();
    monitor();
    @(posedge clk);
    #1;
    if (ps_auto) ps_drive();
  endtask

  task automatic clear_logs();
    ps_q.delete(); ar_addr_q.delete(); dlv_src.delete(); dlv_dat.delete();
    both_rv = 0; data_ctr = 0; ps_beat = 0; r_hold = 0;
  endtask

  task automatic issue_manual(input int s, input logic [AW-1:0] a, input logic [7:0] l);
    if (s == 0) begin s0.arvalid = 1; s0.araddr = a; s0.arlen = l; end
    else        begin s1.arvalid = 1; s1.araddr = a; s1.arlen = l; end
    @(negedge clk); adv();
    s0.arvalid = 0; s1.arvalid = 0; m.arready = 1;
    @(negedge clk); adv();
    m.arready = 0;
  endtask

  task automatic load_req(input int s);
    logic [AW-1:0] a = {16'($urandom), $urandom};
    int l = $urandom_range(0, 3);
    cur_addr[s] = a; cur_len[s] = l;
    if (s == 0) begin s0.araddr = a; s0.arlen = 8'(l); end
    else        begin s1.araddr = a; s1.arlen = 8'(l); end
  endtask

  task automatic test_reset();
    rst = 1;
    {s0.arvalid, s0.araddr, s0.arlen, s0.arsize, s0.arburst, s0.arprot, s0.arcache, s0.aruser, s0.arid} = '0;
    {s1.arvalid, s1.araddr, s1.arlen, s1.arsize, s1.arburst, s1.arprot, s1.arcache, s1.aruser, s1.arid} = '0;
    s0.rready = 1; s1.rready = 1;
    m.arready = 0; m.rvalid = 1; m.rdata = '0; m.rresp = 0; m.rlast = 1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({m.arvalid, s0.arready, s1.arready, s0.rvalid, s1.rvalid, m.rready} !== 6'b0)
        begin errors++; $display("FAIL reset_handshakes: got %b want 000000",
          {m.arvalid, s0.arready, s1.arready, s0.rvalid, s1.rvalid, m.rready}); end
      checks++;
      if ({busy, err} !== 2'b00) begin errors++; $display("FAIL reset_status: busy/err got %b want 00", {busy, err}); end
      checks++;
      if ({m.araddr, m.arlen} !== '0) begin errors++; $display("FAIL reset_payload: got %h want 0", {m.araddr, m.arlen}); end
      adv();
    end
    m.rvalid = 0; m.rlast = 0; rst = 0;
    model_last = 1;
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    logic [1:0] rr;
    logic [2:0] pr = 3'($urandom);
    logic [3:0] ca = 4'($urandom);
    int hold = $urandom_range(1, 3);
    s0.arvalid = 1; s0.araddr = 48'h1000; s0.arlen = 7; s0.arsize = 3; s0.arburst = 1;
    s0.arprot = pr; s0.arcache = ca; s0.aruser = 1; s0.arid = 4'hF;
    @(negedge clk);
    checks++;
    if ({s0.arready, s1.arready, m.arvalid} !== 3'b100)
      begin errors++; $display("FAIL single_grant: got %b want 100", {s0.arready, s1.arready, m.arvalid}); end
    adv();
    s0.arvalid = 0; s0.araddr = {16'($urandom), $urandom}; s0.arlen = 8'($urandom);
    for (int i = 0; i <= hold; i++) begin
      m.arready = (i == hold);
      @(negedge clk);
      checks++;
      if ({m.arvalid, m.arid, m.araddr, m.arlen, m.arsize, m.arburst, m.arprot, m.arcache, m.aruser} !==
          {1'b1, 4'h0, 48'h1000, 8'd7, 3'd3, 2'd1, pr, ca, 1'b1})
        begin errors++; $display("FAIL single_issue: addr %h len %0d arvalid %b arid %h want addr 1000 len 7 arvalid 1 arid 0",
          m.araddr, m.arlen, m.arvalid, m.arid); end
      adv();
    end
    m.arready = 0;
    @(negedge clk);
    checks++;
    if ({m.arvalid, busy} !== 2'b01) begin errors++; $display("FAIL single_after_ar: arvalid/busy %b want 01", {m.arvalid, busy}); end
    adv();
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom}; rr = 2'($urandom);
      m.rvalid = 1; m.rdata = d; m.rresp = rr; m.rlast = (i == 7);
      @(negedge clk);
      checks++;
      if ({s0.rvalid, s1.rvalid, m.rready, busy, s0.rlast} !== {4'b1011, i == 7} || s0.rdata !== d || s0.rresp !== rr || s1.rdata !== d)
        begin errors++; $display("FAIL single_beat%0d: s0v/s1v/rdy/busy %b data %h want 1011 data %h", i,
          {s0.rvalid, s1.rvalid, m.rready, busy}, s0.rdata, d); end
      adv();
    end
    m.rvalid = 0; m.rlast = 0;
    @(negedge clk);
    checks++;
    if ({busy, m.rready} !== 2'b00) begin errors++; $display("FAIL single_busy_drop: busy/rready %b want 00", {busy, m.rready}); end
    adv();
    model_last = 0;
  endtask

  task automatic test_back_to_back();
    int rem[2] = '{6, 6};
    int model_src[$], model_len[$];
    logic [AW-1:0] model_addr[$];
    int total = 0, n = 0, granted, exp, cyc = 0;
    bit g0, g1;
    clear_logs();
    ps_auto = 1; ps_r_en = 1;
    load_req(0); load_req(1);
    s0.arsize = 3; s1.arsize = 3;
    while ((rem[0] + rem[1]) > 0 && cyc < 1500) begin
      s0.arvalid = (rem[0] > 0); s1.arvalid = (rem[1] > 0);
      @(negedge clk);
      granted = -1;
      g0 = s0.arvalid && s0.arready; g1 = s1.arvalid && s1.arready;
      if (g0 || g1) begin
        exp = (rem[0] > 0 && rem[1] > 0) ? 1 - model_last : ((rem[0] > 0) ? 0 : 1);
        checks++;
        if ({g1, g0} !== ((exp == 1) ? 2'b10 : 2'b01))
          begin errors++; $display("FAIL b2b_grant%0d: got s1/s0 %b want source %0d", model_src.size(), {g1, g0}, exp); end
        model_last = exp; granted = exp; rem[exp]--;
        model_src.push_back(exp); model_len.push_back(cur_len[exp]); model_addr.push_back(cur_addr[exp]);
        total += cur_len[exp] + 1;
      end
      adv();
      if (granted >= 0) load_req(granted);
      s0.rready = 1'($urandom); s1.rready = 1'($urandom);
      cyc++;
    end
    s0.arvalid = 0; s1.arvalid = 0;
    checks++;
    if (rem[0] + rem[1] != 0) begin errors++; $display("FAIL b2b_ar_timeout: %0d requests left want 0", rem[0] + rem[1]); end
    cyc = 0;
    while (dlv_src.size() < total && cyc < 1000) begin
      @(negedge clk); adv();
      s0.rready = 1'($urandom); s1.rready = 1'($urandom);
      cyc++;
    end
    checks++;
    if (dlv_src.size() != total) begin errors++; $display("FAIL b2b_beat_count: got %0d want %0d", dlv_src.size(), total); end
    for (int k = 0; k < model_src.size(); k++) begin
      checks++;
      if (k >= ar_addr_q.size() || ar_addr_q[k] !== model_addr[k])
        begin errors++; $display("FAIL b2b_araddr%0d: want %h", k, model_addr[k]); end
      for (int j = 0; j <= model_len[k]; j++) begin
        checks++;
        if (n >= dlv_src.size() || dlv_src[n] != model_src[k] || dlv_dat[n] !== DW'(n))
          begin errors++; $display("FAIL b2b_beat%0d: want source %0d data %0d", n, model_src[k], n); end
        n++;
      end
    end
    checks++;
    if (both_rv != 0) begin errors++; $display("FAIL b2b_both_rvalid: got %0d cycles want 0", both_rv); end
    ps_auto = 0; ps_r_en = 0;
    m.arready = 0; m.rvalid = 0; m.rlast = 0; s0.rready = 1; s1.rready = 1;
  endtask

  task automatic test_full_stall();
    int hits = 0;
    clear_logs();
    for (int k = 0; k < 4; k++) issue_manual(0, {16'($urandom), $urandom}, 8'd0);
    s0.arvalid = 1; s0.araddr = 48'h2000; s0.arlen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (s0.arready || s1.arready) hits++;
      adv();
    end
    checks++;
    if (hits != 0) begin errors++; $display("FAIL full_block: arready seen %0d cycles want 0", hits); end
    m.rvalid = 1; m.rlast = 1; m.rdata = {$urandom, $urandom};
    @(negedge clk);
    checks++;
    if ({s0.arready, m.rready, s0.rvalid, s1.rvalid} !== 4'b0110)
      begin errors++; $display("FAIL full_pop_cycle: arready/rready/s0v/s1v %b want 0110", {s0.arready, m.rready, s0.rvalid, s1.rvalid}); end
    adv();
    m.rvalid = 0;
    @(negedge clk);
    checks++;
    if (s0.arready !== 1'b1) begin errors++; $display("FAIL full_unblock: arready %b want 1", s0.arready); end
    adv();
    s0.arvalid = 0; m.arready = 1;
    @(negedge clk);
    checks++;
    if (m.arvalid !== 1'b1 || m.araddr !== 48'h2000) begin errors++; $display("FAIL full_fifth_issue: arvalid %b addr %h want 1 2000", m.arvalid, m.araddr); end
    adv();
    m.arready = 0;
    for (int i = 0; i < 4; i++) begin
      m.rvalid = 1; m.rlast = 1; m.rdata = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if ({s0.rvalid, s1.rvalid, m.rready} !== 3'b101) begin errors++; $display("FAIL full_drain%0d: s0v/s1v/rdy %b want 101", i, {s0.rvalid, s1.rvalid, m.rready}); end
      adv();
    end
    m.rvalid = 0; m.rlast = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL full_idle: busy %b want 0", busy); end
    adv();
    model_last = 0;
  endtask

  task automatic test_rready_stall();
    logic [DW-1:0] d[6];
    issue_manual(1, {16'($urandom), $urandom}, 8'd5);
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      d[i] = {$urandom, $urandom};
      m.rvalid = 1; m.rdata = d[i]; m.rlast = (i == 5);
      if (i == 2) begin
        s1.rready = 0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          checks++;
          if ({m.rready, s0.rvalid, s1.rvalid} !== 3'b001)
            begin errors++; $display("FAIL stall_cycle%0d: rready/s0v/s1v %b want 001", c, {m.rready, s0.rvalid, s1.rvalid}); end
          adv();
        end
        s1.rready = 1;
      end
      @(negedge clk); adv();
    end
    m.rvalid = 0; m.rlast = 0;
    checks++;
    if (dlv_src.size() != 6) begin errors++; $display("FAIL stall_beat_count: got %0d want 6", dlv_src.size()); end
    for (int i = 0; i < 6 && i < dlv_src.size(); i++) begin
      checks++;
      if (dlv_src[i] != 1 || dlv_dat[i] !== d[i])
        begin errors++; $display("FAIL stall_beat%0d: source %0d data %h want 1 %h", i, dlv_src[i], dlv_dat[i], d[i]); end
    end
    model_last = 1;
  endtask

  task automatic test_unexpected_r();
    m.rvalid = 1; m.rlast = 1; m.rdata = {$urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({m.rready, s0.rvalid, s1.rvalid} !== 3'b000) begin errors++; $display("FAIL unexp_route%0d: rready/s0v/s1v %b want 000", k, {m.rready, s0.rvalid, s1.rvalid}); end
      checks++;
      if (err !== (k == 1)) begin errors++; $display("FAIL unexp_pulse%0d: err %b want %b", k, err, k == 1); end
      adv();
    end
    m.rvalid = 0; m.rlast = 0;
    @(negedge clk); adv();
  endtask

  task automatic test_reset_mid();
    issue_manual(1, 48'h3000, 8'd0);
    issue_manual(0, 48'h4000, 8'd0);
    s1.arvalid = 1; s1.araddr = 48'h5000; s1.arlen = 0;
    @(negedge clk); adv();
    s1.arvalid = 0; m.arready = 0;
    @(negedge clk);
    checks++;
    if (m.arvalid !== 1'b1) begin errors++; $display("FAIL rstmid_setup: arvalid %b want 1", m.arvalid); end
    rst = 1;
    #1;
    checks++;
    if ({m.arvalid, busy} !== 2'b00) begin errors++; $display("FAIL rstmid_clear: arvalid/busy %b want 00", {m.arvalid, busy}); end
    adv();
    rst = 0;
    s0.arvalid = 1; s1.arvalid = 1; s0.araddr = 48'h6000; s1.araddr = 48'h7000;
    @(negedge clk);
    checks++;
    if ({s1.arready, s0.arready} !== 2'b01) begin errors++; $display("FAIL rstmid_first_contest: s1/s0 arready %b want 01", {s1.arready, s0.arready}); end
    adv();
    s0.arvalid = 0; s1.arvalid = 0;
    @(negedge clk);
    checks++;
    if (m.araddr !== 48'h6000) begin errors++; $display("FAIL rstmid_payload: addr %h want 6000", m.araddr); end
    adv();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_stall();
    test_rready_stall();
    test_unexpected_r();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tlk2711_axi_rd_arbiter.md
Name: tlk2711_axi_rd_arbiter

Overview:
- Shares one AXI4 read port (PS HP/HPC) between the tlk2711a and tlk2711b TX DMA read masters.
- Round-robin arbitration on AR; R beats are routed back by a source-order FIFO.
- Sits between the two tlk2711_top m_axi read channels and the PS slave port.
- Write channels are not touched by this block.

Parameters:
ADDR_WIDTH, 48, AR address width
AXI_RDATA_WIDTH, 64, R data width
OUTSTANDING, 4, max bursts in flight (source FIFO depth, 2..16)
M_ARID, 4'h0, fixed ARID driven on master port; a single ID forces in-order return

Ports:
clk  in  1  clock for all logic
rst  in  1  asynchronous reset, active-high
s0_axi_ar{valid,addr,len,size,burst,prot,cache,user}  in  1/ADDR_WIDTH/8/3/2/3/4/1  AR request, source 0 (tlk2711a); arid ignored
s0_axi_arready  out  1  AR accept, source 0
s0_axi_r{data,resp,last,valid}  out  AXI_RDATA_WIDTH/2/1/1  R beat to source 0
s0_axi_rready  in  1  source 0 ready
s1_axi_*  same set as s0  source 1 (tlk2711b)
m_axi_ar{valid,id,addr,len,size,burst,prot,cache,user}  out  1/4/ADDR_WIDTH/8/3/2/3/4/1  AR to PS
m_axi_arready  in  1
m_axi_r{data,resp,last,valid}  in  AXI_RDATA_WIDTH/2/1/1
m_axi_rready  out  1
o_busy  out  1  FIFO non-empty or AR in flight
o_err_unexp_r  out  1  one-cycle pulse: m_axi_rvalid while FIFO empty

Behaviour:
Reset values:
- All outputs 0; FSM=IDLE; FIFO empty; count=0.
- last_grant=1, so source 0 wins the first contest.

AR FSM:
- IDLE: if count+inflight<OUTSTANDING and any s*_arvalid, pick the winner round-robin (the source not equal to last_grant wins ties).
  - Assert the winner's s_arready combinationally this cycle.
  - Latch its payload and source bit; go to ISSUE.
  - If the FIFO is full, both arready stay 0.
- ISSUE: m_axi_arvalid=1 with the registered payload, m_axi_arid=M_ARID.
  - Payload is held stable until m_axi_arready.
  - On handshake: push the source bit into the FIFO, set last_grant=source, return to IDLE.
- AR latency: 1 cycle from s handshake to m_axi_arvalid. Max rate is one AR per 2 cycles.
- inflight = (state==ISSUE); it is counted toward the full check.

R routing:
- FIFO empty: m_axi_rready=0, s*_rvalid=0. If m_axi_rvalid=1, pulse o_err_unexp_r (beat stalls; no drop).
- FIFO non-empty, head=h:
  - sh_rvalid = m_axi_rvalid.
  - m_axi_rready = sh_rready.
  - The other source's rvalid=0.
- rdata/rresp/rlast fan out to both sources unconditionally.
- Pop when m_axi_rvalid & m_axi_rready & m_axi_rlast.

Counters and boundaries:
- Push and pop in the same cycle leave count unchanged. count is $clog2(OUTSTANDING+1) bits.
- Pointers wrap modulo OUTSTANDING.
- Full: no new grant. A pop in the same IDLE cycle does not unblock until the next cycle (full check uses registered count).
- Both requesting continuously: strict alternation 0,1,0,1.
- Reset asserted mid-burst: state is cleared immediately; in-flight beats are the PS side's concern (the system resets both together).

Decomposition:
- Shared package tlk2711_pkg:
  - AR payload struct, localparam SRC_A=0 / SRC_B=1.
  - FSM state enum {IDLE, ISSUE}.
- One sub-module: tlk2711_src_fifo. Synchronous 1-bit FIFO, depth OUTSTANDING, with count/full/empty.

Test Plan:
- Single AR from s0 (addr 0x1000, len 7) -> m_axi_arvalid one cycle after s0 handshake, arid=0. 8 R beats reach only s0; FIFO pops on beat 8; o_busy drops the next cycle.
- s0 and s1 arvalid both held high, 6 requests each, arready=1 -> grant order 0,1,0,1,...; R bursts return in the same order and each reaches only its own source.
- 4 ARs accepted with m_axi_rvalid held 0 -> 5th request stalls (arready=0) until the first rlast handshake; it is granted on the following IDLE cycle.
- s1 holds rready=0 for 10 cycles mid-burst -> m_axi_rready=0 for those cycles; no beat lost or duplicated; s0_rvalid stays 0.
- m_axi_rvalid=1 with empty FIFO -> o_err_unexp_r pulses, m_axi_rready stays 0.
- rst asserted while in ISSUE with count=2 -> next cycle m_axi_arvalid=0, count=0, last_grant=1; the next contest is won by s0.
